wbfillframe: RTL and testbench

Wishbone pipelined bus master that paints a test image into the framebuffer memory that the VGA frame reader later scans out. It sits upstream of the frame reader on the same memory bus, in front of the memory device through a bus arbiter. Software or a bench strobes a start with base address, geometry and pattern. The block streams one write per clock, subject to stall, until every word of the frame is acknowledged.

---
 rtl/wbfillframe_pkg.sv | 13 +
 rtl/wbfillframe_if.sv | 18 +
 rtl/wbfillframe_pattern.sv | 26 ++
 rtl/wbfillframe.sv | 182 ++++++++++++++++++
 tb/tb_wbfillframe.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/wbfillframe_pkg.sv
// Shared types for the wbfillframe test-image writer: FSM states and pattern codes.
package wbfillframe_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, DRAIN} state_t;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_RAMP  = 2'd2,
        PAT_CHECK = 2'd3
    } pat_t;

endpackage

// File: rtl/wbfillframe_if.sv
// Wishbone pipelined write bus between wbfillframe and the memory arbiter.
interface wbfillframe_if #(
    parameter int AW = 24,
    parameter int DW = 32
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW/8-1:0] sel;
    logic          ack;
    logic          stall;
    logic          err;

    modport master (output cyc, stb, we, addr, data, sel, input ack, stall, err);
    modport slave  (input cyc, stb, we, addr, data, sel, output ack, stall, err);
endinterface

// File: rtl/wbfillframe_pattern.sv
// wbfill_pattern: combinational pixel word from column bit 3, line low byte and bar index.
// Built only when WBFILL_PATTERNS_EN is defined.
`ifdef WBFILL_PATTERNS_EN
module wbfill_pattern
    import wbfillframe_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          col_b3,
    input  logic [7:0]    line_lo,
    input  logic [2:0]    bar,
    input  pat_t          pattern,
    input  logic [DW-1:0] color,
    output logic [DW-1:0] word
);
    always_comb begin
        word = color;
        unique case (pattern)
            PAT_BARS:  word = DW'({8'h00, {8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}});
            PAT_RAMP:  word = {(DW/8){line_lo}};
            PAT_CHECK: word = (col_b3 ^ line_lo[3]) ? color : '0;
            default:   word = color;
        endcase
    end
endmodule
`endif

// File: rtl/wbfillframe.sv
// wbfillframe: Wishbone pipelined master that paints a test frame into memory.
// Bars/ramp/checker patterns are built only with WBFILL_PATTERNS_EN defined.
module wbfillframe
    import wbfillframe_pkg::*;
#(
    parameter int AW    = 24,
    parameter int DW    = 32,
    parameter int FW    = 13,
    parameter int LW    = 11,
    parameter int LGOUT = 4
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_start,
    input  logic [AW-1:0] i_base,
    input  logic [FW-1:0] i_width,
    input  logic [LW-1:0] i_height,
    input  logic [1:0]    i_pattern,
    input  logic [DW-1:0] i_color,
    wbfillframe_if.master wb,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);
    localparam logic [LGOUT:0] OUT_MAX = {1'b1, {LGOUT{1'b0}}};

    state_t         state, state_nxt;
    logic [FW-1:0]  width_q, col, n_col;
    logic [LW-1:0]  height_q, line, n_line;
    logic [AW-1:0]  ptr, n_ptr, addr_q;
    logic [DW-1:0]  color_q, data_q, p_color, p_word;
    logic [LGOUT:0] cnt, cnt_nxt;
    logic cyc, stb, accept, ack_ok, bus_err, eol, last;
    logic start_ok, degen, done_nxt, done_q, err_q;

    assign cyc      = (state != IDLE);
    assign stb      = (state == WRITE) && (cnt != OUT_MAX);
    assign wb.cyc   = cyc;
    assign wb.stb   = stb;
    assign wb.we    = cyc;
    assign wb.addr  = addr_q;
    assign wb.data  = data_q;
    assign wb.sel   = '1;
    assign o_busy   = cyc;
    assign o_done   = done_q;
    assign o_err    = err_q;

    assign accept   = stb && !wb.stall;
    assign ack_ok   = cyc && wb.ack && (cnt != '0);
    assign bus_err  = cyc && wb.err;
    assign eol      = (col == width_q - FW'(1));
    assign last     = eol && (line == height_q - LW'(1));
    assign start_ok = (state == IDLE) && i_start;
    assign degen    = (i_width == '0) || (i_height == '0);
    assign cnt_nxt  = cnt + {{LGOUT{1'b0}}, accept} - {{LGOUT{1'b0}}, ack_ok};

    // Coordinates of the word that follows the one currently on the bus.
    assign n_col   = eol ? '0 : col + FW'(1);
    assign n_line  = eol ? line + LW'(1) : line;
    assign n_ptr   = eol ? ptr + AW'(width_q) : ptr;
    assign p_color = (state == IDLE) ? i_color : color_q;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE:  if (start_ok) begin
                       if (degen) done_nxt = 1'b1;
                       else       state_nxt = WRITE;
                   end
            WRITE: if (accept && last) state_nxt = DRAIN;
            DRAIN: if (cnt_nxt == '0) begin
                       state_nxt = IDLE;
                       done_nxt  = 1'b1;
                   end
            default: state_nxt = IDLE;
        endcase
        if (bus_err) begin
            state_nxt = IDLE;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            width_q  <= '0;
            height_q <= '0;
            color_q  <= '0;
            col      <= '0;
            line     <= '0;
            ptr      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            cnt      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= done_nxt;
            cnt    <= bus_err ? '0 : cnt_nxt;
            if (bus_err)       err_q <= 1'b1;
            else if (start_ok) err_q <= 1'b0;
            if (start_ok) begin
                width_q  <= i_width;
                height_q <= i_height;
                color_q  <= i_color;
                col      <= '0;
                line     <= '0;
                ptr      <= i_base;
                addr_q   <= i_base;
                data_q   <= p_word;
            end else if (accept) begin
                col    <= n_col;
                line   <= n_line;
                ptr    <= n_ptr;
                addr_q <= n_ptr + AW'(n_col);
                data_q <= p_word;
            end
        end
    end

`ifdef WBFILL_PATTERNS_EN
    pat_t          pat_q, p_pat;
    logic [FW-1:0] bar_w, bar_cnt, n_bar_cnt;
    logic [2:0]    bar, n_bar, p_bar;
    logic [7:0]    p_line;
    logic          p_col3;

    // Bar index is tracked incrementally so no divider is needed.
    assign bar_w = (width_q < FW'(8)) ? FW'(1) : (width_q >> 3);

    always_comb begin
        n_bar     = bar;
        n_bar_cnt = bar_cnt + FW'(1);
        if (eol) begin
            n_bar     = '0;
            n_bar_cnt = '0;
        end else if (bar != 3'd7 && bar_cnt == bar_w - FW'(1)) begin
            n_bar     = bar + 3'd1;
            n_bar_cnt = '0;
        end
    end

    assign p_pat  = (state == IDLE) ? pat_t'(i_pattern) : pat_q;
    assign p_bar  = (state == IDLE) ? 3'd0 : n_bar;
    assign p_line = (state == IDLE) ? 8'd0 : n_line[7:0];
    assign p_col3 = (state == IDLE) ? 1'b0 : n_col[3];

    wbfill_pattern #(.DW(DW)) u_pattern (
        .col_b3  (p_col3),
        .line_lo (p_line),
        .bar     (p_bar),
        .pattern (p_pat),
        .color   (p_color),
        .word    (p_word)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pat_q   <= PAT_SOLID;
            bar     <= '0;
            bar_cnt <= '0;
        end else if (start_ok) begin
            pat_q   <= pat_t'(i_pattern);
            bar     <= '0;
            bar_cnt <= '0;
        end else if (accept) begin
            bar     <= n_bar;
            bar_cnt <= n_bar_cnt;
        end
    end
`else
    logic [1:0] unused_pattern;
    assign unused_pattern = i_pattern;
    assign p_word = p_color;
`endif

endmodule

// File: tb/tb_wbfillframe.sv
// Directed self-checking bench for wbfillframe with a small pipelined Wishbone slave.
module tb_wbfillframe;
`ifdef WBFILL_PATTERNS_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [23:0] i_base;
    logic [12:0] i_width;
    logic [10:0] i_height;
    logic [1:0]  i_pattern;
    logic [31:0] i_color;
    logic        o_busy, o_done, o_err;

    wbfillframe_if #(.AW(24), .DW(32)) wb ();

    wbfillframe #(.AW(24), .DW(32), .FW(13), .LW(11), .LGOUT(2)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_start   (i_start),
        .i_base    (i_base),
        .i_width   (i_width),
        .i_height  (i_height),
        .i_pattern (i_pattern),
        .i_color   (i_color),
        .wb        (wb),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int ack_lat = 1, stall_mode = 0, err_on = 0;
    int cnum = 0, resp_n = 0;
    int done_cnt, cyc_cycles, err_viol, hold_viol, lim_viol, lim_cycles, out_m, max_out;
    int due_q[$];
    logic [23:0] log_a[$];
    logic [31:0] log_d[$];
    logic        err_seen, hold_pend;
    logic [23:0] h_addr;
    logic [31:0] h_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Slave: responses driven just after the rising edge, bus sampled on the falling edge.
    initial begin : slave
        wb.ack = 1'b0; wb.err = 1'b0; wb.stall = 1'b0;
        forever begin
            @(posedge clk); #1;
            cnum++;
            wb.ack = 1'b0; wb.err = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cnum) begin
                void'(due_q.pop_front());
                resp_n++;
                if (resp_n == err_on) wb.err = 1'b1;
                else                  wb.ack = 1'b1;
            end
            wb.stall = (stall_mode == 1) && cnum[0];
            @(negedge clk);
            if (o_done) done_cnt++;
            if (wb.cyc) cyc_cycles++;
            if (err_seen && wb.cyc) err_viol++;
            err_seen = wb.cyc && wb.err;
            if (hold_pend && (wb.stb !== 1'b1 || wb.addr !== h_addr || wb.data !== h_data)) hold_viol++;
            hold_pend = wb.stb && wb.stall;
            h_addr = wb.addr; h_data = wb.data;
            if (out_m == 4 && wb.stb) lim_viol++;
            if (out_m == 4 && wb.cyc) lim_cycles++;
            if (wb.stb && !wb.stall) begin
                log_a.push_back(wb.addr);
                log_d.push_back(wb.data);
                due_q.push_back(cnum + ack_lat);
                out_m++;
            end
            if (wb.cyc && wb.ack && out_m > 0) out_m--;
            if (wb.cyc && wb.err) out_m = 0;
            if (out_m > max_out) max_out = out_m;
        end
    end

    task automatic kick(input logic [23:0] base, input logic [12:0] w, input logic [10:0] h,
                        input logic [1:0] pat, input logic [31:0] col, input int lat, input int stm,
                        input int eon);
        @(posedge clk); #2;
        ack_lat = lat; stall_mode = stm; err_on = eon; resp_n = 0;
        due_q.delete(); log_a.delete(); log_d.delete();
        done_cnt = 0; cyc_cycles = 0; err_viol = 0; hold_viol = 0; lim_viol = 0; lim_cycles = 0;
        out_m = 0; max_out = 0; err_seen = 1'b0; hold_pend = 1'b0;
        i_start = 1'b1; i_base = base; i_width = w; i_height = h; i_pattern = pat; i_color = col;
        @(posedge clk); #2;
        i_start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [23:0] base, input logic [12:0] w,
                       input logic [10:0] h, input logic [1:0] pat, input logic [31:0] col,
                       input int lat, input int stm, input int eon, input logic exp_done,
                       input logic [31:0] exp_d0);
        kick(base, w, h, pat, col, lat, stm, eon);
        @(negedge clk);
        if (w != 0 && h != 0) begin
            chk({tag, "_first_stb"},  {31'd0, wb.stb}, 32'd1);
            chk({tag, "_first_addr"}, {8'd0, wb.addr}, {8'd0, base});
            chk({tag, "_first_data"}, wb.data, exp_d0);
            chk({tag, "_first_busy"}, {31'd0, o_busy}, 32'd1);
            chk({tag, "_first_err"},  {31'd0, o_err}, 32'd0);
        end else begin
            chk({tag, "_first_cyc"},  {31'd0, wb.cyc}, 32'd0);
        end
        for (int k = 0; k < 2000 && o_busy; k++) @(negedge clk);
        chk({tag, "_timeout"}, {31'd0, o_busy}, 32'd0);
        chk({tag, "_done"},    {31'd0, o_done}, {31'd0, exp_done});
        @(negedge clk);
        chk({tag, "_done_cnt"}, done_cnt, {31'd0, exp_done});
    endtask

    initial begin
        logic [31:0] bars[8];
        bars = '{32'h000000, 32'h0000FF, 32'h00FF00, 32'h00FFFF,
                 32'hFF0000, 32'hFF00FF, 32'hFFFF00, 32'hFFFFFF};
        rst_n = 1'b0; i_start = 1'b0; i_base = '0; i_width = '0; i_height = '0;
        i_pattern = '0; i_color = '0;
        repeat (3) @(negedge clk);
        chk("rst_cyc",  {31'd0, wb.cyc}, 32'd0);
        chk("rst_stb",  {31'd0, wb.stb}, 32'd0);
        chk("rst_we",   {31'd0, wb.we}, 32'd0);
        chk("rst_addr", {8'd0, wb.addr}, 32'd0);
        chk("rst_data", wb.data, 32'd0);
        chk("rst_sel",  {28'd0, wb.sel}, 32'hF);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_err",  {31'd0, o_err}, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;

        // Solid, zero-wait ack.
        run("solid", 24'h100, 13'd4, 11'd2, 2'd0, 32'h00FF00FF, 1, 0, 0, 1'b1, 32'h00FF00FF);
        chk("solid_n", log_a.size(), 8);
        chk("solid_cyc_cycles", cyc_cycles, 9);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("solid_a%0d", i), {8'd0, log_a[i]}, 32'h100 + i);
            chk($sformatf("solid_d%0d", i), log_d[i], 32'h00FF00FF);
        end

        // Stall every second cycle.
        run("stall", 24'h100, 13'd4, 11'd2, 2'd0, 32'h00FF00FF, 1, 1, 0, 1'b1, 32'h00FF00FF);
        chk("stall_n", log_a.size(), 8);
        chk("stall_hold", hold_viol, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("stall_a%0d", i), {8'd0, log_a[i]}, 32'h100 + i);
            chk($sformatf("stall_d%0d", i), log_d[i], 32'h00FF00FF);
        end

        // Outstanding limit of 4 with 10-cycle ack, base near the top to wrap.
        run("limit", 24'hFFFFFE, 13'd4, 11'd2, 2'd0, 32'hA5A5A5A5, 10, 0, 0, 1'b1, 32'hA5A5A5A5);
        chk("limit_max_out", max_out, 4);
        chk("limit_stb_at_max", lim_viol, 0);
        chk("limit_reached", {31'd0, lim_cycles > 0}, 32'd1);
        chk("limit_n", log_a.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("limit_a%0d", i), {8'd0, log_a[i]}, {8'd0, 24'(32'hFFFFFE + i)});

        // Vertical bars over 16 columns: each colour for two words.
        run("bars", 24'h000, 13'd16, 11'd1, 2'd1, 32'h12345678, 1, 0, 0, 1'b1,
            PAT_EN ? 32'h0 : 32'h12345678);
        chk("bars_n", log_d.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("bars_d%0d", i), log_d[i], PAT_EN ? bars[i / 2] : 32'h12345678);

        // Ramp: each line's low byte replicated.
        run("ramp", 24'h040, 13'd2, 11'd3, 2'd2, 32'hDEADBEEF, 1, 0, 0, 1'b1,
            PAT_EN ? 32'h0 : 32'hDEADBEEF);
        chk("ramp_d3", log_d[3], PAT_EN ? 32'h01010101 : 32'hDEADBEEF);
        chk("ramp_d4", log_d[4], PAT_EN ? 32'h02020202 : 32'hDEADBEEF);
        chk("ramp_a5", {8'd0, log_a[5]}, 32'h045);

        // Checkerboard, 16x9: tiles flip at column 8 and line 8.
        run("check", 24'h000, 13'd16, 11'd9, 2'd3, 32'h00C0FFEE, 1, 0, 0, 1'b1,
            PAT_EN ? 32'h0 : 32'h00C0FFEE);
        chk("check_n", log_d.size(), 144);
        chk("check_d8",   log_d[8],   32'h00C0FFEE);
        chk("check_d128", log_d[128], 32'h00C0FFEE);
        chk("check_d136", log_d[136], PAT_EN ? 32'h0 : 32'h00C0FFEE);
        chk("check_a136", {8'd0, log_a[136]}, 32'd136);

        // Bus error on the third response: abort, sticky error, no done.
        run("err", 24'h200, 13'd4, 11'd2, 2'd0, 32'h11111111, 1, 0, 3, 1'b0, 32'h11111111);
        chk("err_flag", {31'd0, o_err}, 32'd1);
        chk("err_cyc_drop", err_viol, 0);
        run("after_err", 24'h300, 13'd4, 11'd2, 2'd0, 32'h22222222, 1, 0, 0, 1'b1, 32'h22222222);
        chk("after_err_flag", {31'd0, o_err}, 32'd0);
        chk("after_err_n", log_a.size(), 8);

        // Degenerate geometry: done next cycle, no bus activity.
        run("degen", 24'h400, 13'd0, 11'd5, 2'd0, 32'h33333333, 1, 0, 0, 1'b1, 32'h0);
        chk("degen_cyc_cycles", cyc_cycles, 0);

        // Asynchronous reset in the middle of a frame.
        kick(24'h500, 13'd4, 11'd2, 2'd0, 32'h44444444, 10, 0, 0);
        repeat (2) @(negedge clk);
        chk("arst_pre_cyc", {31'd0, wb.cyc}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cyc",  {31'd0, wb.cyc}, 32'd0);
        chk("arst_stb",  {31'd0, wb.stb}, 32'd0);
        chk("arst_busy", {31'd0, o_busy}, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("arst_idle_cyc",  {31'd0, wb.cyc}, 32'd0);
        chk("arst_idle_busy", {31'd0, o_busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
